// File: rtl/trigger_t_pkg.sv
// rtl/trigger_t_pkg.sv - shared constants and FSM state type for the T-trigger decoder
package trigger_t_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [15:0] TOGGLE_CNT_MAX = 16'hFFFF;

  // IDLE: no bits collected, SHIFT: partial word, FULL: output word pending
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/trigger_t_decoder_toggle_detect.sv
// rtl/trigger_t_decoder_toggle_detect.sv - recovers t bits from T-trigger output level changes
module toggle_detect (
  input  logic clk,
  input  logic rst,
  input  logic q_in,
  output logic bit_o
);

  logic q_prev_q;

  // Track the previous level every cycle so gaps in sampling never create a spurious bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_prev_q <= 1'b0;
    end else begin
      q_prev_q <= q_in;
    end
  end

  assign bit_o = q_in ^ q_prev_q;

endmodule

// File: rtl/trigger_t_decoder.sv
// rtl/trigger_t_decoder.sv - deserialises T-trigger encoded bits into words with valid/ready output
module trigger_t_decoder
  import trigger_t_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_in,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             overflow,
  output logic [15:0]      toggle_cnt
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic             dbit;
  logic [WIDTH-1:0] word;
  logic             last_bit;
  logic             valid_now;

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q,   shift_d;
  logic [WIDTH-1:0] data_q,    data_d;
  logic             ovf_q,     ovf_d;
  logic [15:0]      tcnt_q,    tcnt_d;
  logic             valid_d;

  toggle_detect u_toggle_detect (
    .clk   (clk),
    .rst   (rst),
    .q_in  (q_in),
    .bit_o (dbit)
  );

  assign valid_now = (state_q == FULL);
  assign word      = {shift_q[WIDTH-2:0], dbit};
  // clr suppresses the sample, so a word cannot complete on a clearing edge
  assign last_bit  = en && !clr && (bit_cnt_q == LAST_CNT);

  // Next-state: collection, output handshake, overflow and toggle counting
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ovf_d     = ovf_q;
    tcnt_d    = tcnt_q;
    valid_d   = valid_now;
    state_d   = state_q;

    if (clr) begin
      bit_cnt_d = '0;
      shift_d   = '0;
      ovf_d     = 1'b0;
    end else if (en) begin
      shift_d   = word;
      bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
      if (dbit && (tcnt_q != TOGGLE_CNT_MAX)) begin
        tcnt_d = tcnt_q + 16'd1;
      end
    end

    // A completing word may replace one being consumed on the same edge
    if (last_bit) begin
      if (!valid_now || ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_now && ready) begin
      valid_d = 1'b0;
    end

    if (valid_d) begin
      state_d = FULL;
    end else if (bit_cnt_d != '0) begin
      state_d = SHIFT;
    end else begin
      state_d = IDLE;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_now;
  assign overflow   = ovf_q;
  assign toggle_cnt = tcnt_q;

endmodule

// File: tb/tb_trigger_t_decoder.sv
// tb/tb_trigger_t_decoder.sv - self-checking bench for trigger_t_decoder
module tb_trigger_t_decoder;

  logic        clk;
  logic        rst;
  logic        q_in;
  logic        en;
  logic        clr;
  logic [7:0]  data_out;
  logic        valid;
  logic        ready;
  logic        overflow;
  logic [15:0] toggle_cnt;

  int checks = 0;
  int errors = 0;

  // T-trigger model state and a bit-level reference of the collected word
  logic        tq;
  logic [7:0]  mdl_sr;
  int          mdl_cnt;
  logic [15:0] exp_tcnt;
  logic        auto_push;
  logic [7:0]  exp_q[$];

  typedef struct {
    logic [7:0]  word;
    logic [15:0] tcnt;
  } vec_t;

  vec_t vecs[5];

  trigger_t_decoder #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .q_in       (q_in),
    .en         (en),
    .clr        (clr),
    .data_out   (data_out),
    .valid      (valid),
    .ready      (ready),
    .overflow   (overflow),
    .toggle_cnt (toggle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted word must match the oldest expected word
  always @(negedge clk) begin
    if (rst && valid && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h expected none", data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL sb_word: got %h expected %h", data_out, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    tq       = 1'b0;
    q_in     = 1'b0;
    mdl_sr   = 8'h00;
    mdl_cnt  = 0;
    exp_tcnt = 16'h0000;
  endtask

  task automatic send_bit(input logic t);
    tq   = tq ^ t;
    q_in = tq;
    en   = 1'b1;
    step();
    if (!clr) begin
      if (t && exp_tcnt != 16'hFFFF) exp_tcnt = exp_tcnt + 16'd1;
      mdl_sr = {mdl_sr[6:0], t};
      mdl_cnt++;
      if (mdl_cnt == 8) begin
        mdl_cnt = 0;
        if (auto_push) exp_q.push_back(mdl_sr);
      end
    end else begin
      mdl_sr  = 8'h00;
      mdl_cnt = 0;
    end
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic idle();
    en = 1'b0;
    step();
  endtask

  initial begin
    vecs[0] = '{word: 8'h00, tcnt: 16'd0};
    vecs[1] = '{word: 8'hB2, tcnt: 16'd4};
    vecs[2] = '{word: 8'h5A, tcnt: 16'd8};
    vecs[3] = '{word: 8'hFF, tcnt: 16'd16};
    vecs[4] = '{word: 8'h01, tcnt: 16'd17};

    rst = 1'b0; en = 1'b0; clr = 1'b0; ready = 1'b1; auto_push = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", data_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_tcnt", toggle_cnt, 0);
    rst = 1'b1;
    step();

    // Table-driven words with ready held high
    for (int v = 0; v < 5; v++) begin
      send_word(vecs[v].word);
      chk($sformatf("tbl%0d_valid", v), valid, 1);
      chk($sformatf("tbl%0d_data", v), data_out, vecs[v].word);
      chk($sformatf("tbl%0d_tcnt", v), toggle_cnt, vecs[v].tcnt);
      idle();
      chk($sformatf("tbl%0d_consumed", v), valid, 0);
    end

    // Second word dropped while output is still held
    ready = 1'b0; auto_push = 1'b0;
    send_word(8'hB2);
    send_word(8'h5A);
    chk("ovf_data", data_out, 8'hB2);
    chk("ovf_valid", valid, 1);
    chk("ovf_flag", overflow, 1);
    chk("ovf_tcnt", toggle_cnt, exp_tcnt);
    clr = 1'b1;
    idle();
    clr = 1'b0;
    chk("clr_ovf", overflow, 0);
    chk("clr_valid", valid, 1);
    chk("clr_data", data_out, 8'hB2);
    exp_q.push_back(8'hB2);
    ready = 1'b1; auto_push = 1'b1;
    idle();
    chk("ovf_drained", valid, 0);

    // Sampling paused mid-word while the trigger keeps toggling
    send_bit(1); send_bit(1); send_bit(0); send_bit(0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tq   = ~tq;
      q_in = tq;
      step();
    end
    send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    chk("engate_data", data_out, 8'hC6);
    chk("engate_valid", valid, 1);
    chk("engate_tcnt", toggle_cnt, exp_tcnt);
    idle();

    // Asynchronous reset in the middle of a word
    send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(1);
    en = 1'b0;
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst_data", data_out, 0);
    chk("arst_valid", valid, 0);
    chk("arst_tcnt", toggle_cnt, 0);
    chk("arst_ovf", overflow, 0);
    step();
    rst = 1'b1;
    send_word(8'h3C);
    chk("post_rst_data", data_out, 8'h3C);
    chk("post_rst_tcnt", toggle_cnt, 16'd4);
    idle();

    // clr on the completing edge wins over the load
    for (int i = 7; i >= 1; i--) send_bit(i[0]);
    clr = 1'b1;
    send_bit(1);
    clr = 1'b0;
    chk("clr_last_valid", valid, 0);
    chk("clr_last_ovf", overflow, 0);
    chk("clr_last_tcnt", toggle_cnt, exp_tcnt);
    idle();
    send_word(8'hA5);
    chk("after_clr_data", data_out, 8'hA5);
    idle();

    // Toggle counter saturation
    rst = 1'b0;
    model_reset();
    step();
    rst = 1'b1;
    for (int i = 0; i < 65534; i++) send_bit(1);
    chk("sat_pre", toggle_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) send_bit(1);
    chk("sat_max", toggle_cnt, 16'hFFFF);
    chk("sat_model", toggle_cnt, exp_tcnt);
    idle();
    idle();
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trigger_t_decoder.md
TRIGGER_T_DECODER -- requirements
Module: trigger_t_decoder

Interface
REQ-001 Parameter: WIDTH, default 8, deserialised word width (2..16).
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 q_in  input  1  level output of a T-trigger; each level change encodes t=1, no change encodes t=0.
REQ-005 en  input  1  bit-sampling enable; when low, shift register and bit count hold.
REQ-006 clr  input  1  synchronous clear of bit count, shift register and overflow flag.
REQ-007 data_out  output  WIDTH  decoded word, first-received bit in MSB.
REQ-008 valid  output  1  data_out holds an unconsumed word.
REQ-009 ready  input  1  consumer accepts data_out when valid & ready at a rising edge.
REQ-010 overflow  output  1  sticky: a completed word was dropped.
REQ-011 toggle_cnt  output  16  number of decoded t=1 bits, saturating.

Function
REQ-012 q_prev SHALL register q_in on every rising edge regardless of en; decoded bit = q_in ^ q_prev.
REQ-013 With en=1, each edge SHALL shift the decoded bit into the LSB of the shift register and increment bit_cnt.
REQ-014 FSM states SHALL be IDLE (bit_cnt=0, nothing collected), SHIFT (0<bit_cnt<WIDTH), FULL (word complete, output register occupied).
REQ-015 IDLE->SHIFT on the first en=1 edge; SHIFT->IDLE when the WIDTH-th bit is shifted in (bit_cnt wraps to 0).
REQ-016 On the edge that shifts in the WIDTH-th bit: if valid=0, or valid=1 and ready=1 on that edge, data_out SHALL load the complete word and valid SHALL be 1 after that edge (latency: valid visible in the cycle after the final bit is presented).
REQ-017 On the edge that shifts in the WIDTH-th bit while valid=1 and ready=0, the word SHALL be dropped, data_out SHALL be unchanged and overflow SHALL set.
REQ-018 valid & ready at an edge with no new word completing SHALL clear valid; data_out holds its last value.
REQ-019 FULL is the state with valid=1; SHIFT/IDLE collection SHALL continue while FULL (collection never stalls).
REQ-020 toggle_cnt SHALL increment on each en=1 edge with decoded bit 1 and saturate at 16'hFFFF.
REQ-021 clr=1 SHALL zero bit_cnt, shift register and overflow on that edge and discard any bit sampled on that edge; valid, data_out and toggle_cnt are unaffected.
REQ-022 clr and a word completion on the same edge: clr SHALL win (no load, no overflow).
REQ-023 en=0 SHALL not affect valid/ready handshake or q_prev tracking.

Reset
REQ-024 rst=0 SHALL asynchronously force: q_prev=0, bit_cnt=0, shift register=0, data_out=0, valid=0, overflow=0, toggle_cnt=0, state=IDLE.
REQ-025 Reset mid-word SHALL discard the partial word; after release decoding restarts at bit 0, with q_prev=0 matching the T-trigger reset level.

Structure
REQ-026 Package trigger_t_pkg SHALL hold the default WIDTH constant, the FSM state enum (IDLE, SHIFT, FULL) and the TOGGLE_CNT_MAX constant.
REQ-027 Sub-module toggle_detect SHALL contain q_prev and the XOR, outputting the decoded bit; everything else stays in trigger_t_decoder.

Verification
REQ-028 Reset, then q_in held 0 for 8 en cycles -> data_out=8'h00, valid=1 one cycle after 8th bit, toggle_cnt=0.
REQ-029 q_in driven by a T-trigger model fed t=1,0,1,1,0,0,1,0 with en=1, ready=1 -> data_out=8'hB2, valid high one cycle, toggle_cnt=4.
REQ-030 Two words 8'hB2, 8'h5A with ready=0 throughout -> data_out=8'hB2, valid=1, overflow=1; clr pulse -> overflow=0, valid still 1.
REQ-031 en=0 for 3 cycles in mid-word with q_in toggling -> those toggles not decoded, word after resume matches en=1 bits only; q_prev tracking prevents a spurious bit on resume.
REQ-032 rst asserted after 5 bits -> all outputs 0 immediately (asynchronous); next 8 bits produce a full correct word.
REQ-033 Preload toggle_cnt to 16'hFFFE via 2^16-2 decoded 1-bits, then 3 more -> toggle_cnt=16'hFFFF.
